// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared encodings for the multi-channel PWM ramp controller
//
// Purpose: channel FSM state encoding and cool/heat mode encoding used by
//          pwm_ramp_chan and pwm_ramp_ctrl.
// Ports:   none (package).
package pwm_pkg;

  typedef logic [1:0] chan_state_t;

  // Channel FSM states
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  // Actuator selection
  localparam logic MODE_COOL = 1'b0;
  localparam logic MODE_HEAT = 1'b1;

endpackage

// File: rtl/pwm_ramp_chan.sv
// rtl/pwm_ramp_chan.sv - one channel: duty ramp, cool/heat interlock FSM, PWM output mux
//
// Purpose: slews the applied duty toward the requested speed once per PWM
//          period and sequences cool/heat changes as drain -> dead time -> ramp up.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   en_i           run enable (outputs are forced low while 0)
//   boundary_i     last clock of a period; the only edge where state updates
//   cnt_i          shared period counter
//   speed_i        target duty for this channel
//   mode_i         requested mode, 0 = cool, 1 = heat
//   pwm_cool_o     registered cool PWM
//   pwm_heat_o     registered heat PWM
//   duty_o         duty currently applied
//   settled_o      registered: RUN, duty == speed and active mode == mode
module pwm_ramp_chan
  import pwm_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int RAMP_STEP    = 1,
  parameter int DEAD_PERIODS = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             boundary_i,
  input  logic [WIDTH-1:0] cnt_i,
  input  logic [WIDTH-1:0] speed_i,
  input  logic             mode_i,
  output logic             pwm_cool_o,
  output logic             pwm_heat_o,
  output logic [WIDTH-1:0] duty_o,
  output logic             settled_o
);

  localparam int               DW        = $clog2(DEAD_PERIODS + 1);
  localparam logic [WIDTH-1:0] STEP      = WIDTH'(RAMP_STEP);
  localparam logic [DW-1:0]    DEAD_LOAD = DW'(DEAD_PERIODS);
  localparam logic [DW-1:0]    DEAD_ONE  = DW'(1);

  chan_state_t      state_q, state_d;
  logic             active_q, active_d;
  logic [DW-1:0]    dead_q, dead_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             cool_q, heat_q, settled_q;
  logic [WIDTH-1:0] up_ramp, down_ramp;
  logic             pwm_on;

  // Move cur toward tgt by at most STEP; the step is clipped to the gap so
  // the result can neither overshoot nor wrap.
  function automatic logic [WIDTH-1:0] approach(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] tgt);
    logic [WIDTH-1:0] gap;
    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] res;
    gap   = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
    delta = (gap < STEP) ? gap : STEP;
    res   = (tgt >= cur) ? (cur + delta) : (cur - delta);
    return res;
  endfunction

  assign up_ramp   = approach(duty_q, speed_i);
  assign down_ramp = approach(duty_q, '0);

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    dead_d   = dead_q;
    duty_d   = duty_q;
    if (boundary_i) begin
      case (state_q)
        // RUN and DRAIN share the drain step: the edge that detects the mode
        // mismatch already applies the first downward step, and reaching zero
        // on that step goes straight to the dead time.
        ST_RUN, ST_DRAIN: begin
          if (mode_i != active_q) begin
            duty_d = down_ramp;
            if (down_ramp == '0) begin
              state_d = ST_DEAD;
              dead_d  = DEAD_LOAD;
            end else begin
              state_d = ST_DRAIN;
            end
          end else begin
            state_d = ST_RUN;
            duty_d  = up_ramp;
          end
        end
        // The dead time always runs to completion; the mode taken is the one
        // sampled on the final dead boundary, which also applies the first
        // ramp-up step so the next period is already driven.
        ST_DEAD: begin
          dead_d = dead_q - DEAD_ONE;
          if (dead_q <= DEAD_ONE) begin
            state_d  = ST_RUN;
            active_d = mode_i;
            dead_d   = '0;
            duty_d   = up_ramp;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // cnt_i never reaches duty on the boundary clock, so duty/active changes
  // on that edge cannot shorten or glitch a pulse.
  assign pwm_on = en_i && (state_q != ST_DEAD) && (cnt_i < duty_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      active_q  <= MODE_COOL;
      dead_q    <= '0;
      duty_q    <= '0;
      cool_q    <= 1'b0;
      heat_q    <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      dead_q    <= dead_d;
      duty_q    <= duty_d;
      cool_q    <= pwm_on && (active_q == MODE_COOL);
      heat_q    <= pwm_on && (active_q == MODE_HEAT);
      settled_q <= (state_q == ST_RUN) && (duty_q == speed_i) && (active_q == mode_i);
    end
  end

  assign pwm_cool_o = cool_q;
  assign pwm_heat_o = heat_q;
  assign duty_o     = duty_q;
  assign settled_o  = settled_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - multi-channel soft-start PWM controller with cool/heat interlock
//
// Purpose: shared period counter and period-start pulse, plus one
//          pwm_ramp_chan per channel.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   en_i             run enable; 0 clears the counter and holds channel state
//   speed_i          per-channel target duty, channel i at [i*WIDTH +: WIDTH]
//   mode_i           per-channel requested mode, 0 = cool, 1 = heat
//   pwm_cool_o       per-channel cool PWM
//   pwm_heat_o       per-channel heat PWM
//   duty_cur_o       per-channel applied duty
//   period_start_o   one-clock pulse on the first clock of each period
//   settled_o        per-channel settled flag
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CHANNELS     = 2,
  parameter int RAMP_STEP    = 1,
  parameter int DEAD_PERIODS = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i,
  input  logic [CHANNELS*WIDTH-1:0] speed_i,
  input  logic [CHANNELS-1:0]       mode_i,
  output logic [CHANNELS-1:0]       pwm_cool_o,
  output logic [CHANNELS-1:0]       pwm_heat_o,
  output logic [CHANNELS*WIDTH-1:0] duty_cur_o,
  output logic                      period_start_o,
  output logic [CHANNELS-1:0]       settled_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ps_q;
  logic             boundary;

  assign cnt_d    = en_i ? (cnt_q + WIDTH'(1)) : '0;
  assign boundary = en_i && (cnt_q == '1);

  // period_start is registered alongside the pwm outputs so both lag the
  // counter by one clock and the first high clock lines up with the pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ps_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ps_q  <= en_i && (cnt_q == '0);
    end
  end

  assign period_start_o = ps_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pwm_ramp_chan #(
      .WIDTH       (WIDTH),
      .RAMP_STEP   (RAMP_STEP),
      .DEAD_PERIODS(DEAD_PERIODS)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (en_i),
      .boundary_i (boundary),
      .cnt_i      (cnt_q),
      .speed_i    (speed_i[g*WIDTH +: WIDTH]),
      .mode_i     (mode_i[g]),
      .pwm_cool_o (pwm_cool_o[g]),
      .pwm_heat_o (pwm_heat_o[g]),
      .duty_o     (duty_cur_o[g*WIDTH +: WIDTH]),
      .settled_o  (settled_o[g])
    );
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - self-checking bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

  localparam int W     = 8;
  localparam int CH    = 2;
  localparam int STEP  = 16;
  localparam int DEADP = 2;
  localparam int PER   = 256;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic [CH*W-1:0] speed;
  logic [CH-1:0]   mode;
  logic [CH-1:0]   pwm_cool, pwm_heat, settled;
  logic [CH*W-1:0] duty_cur;
  logic            period_start;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .WIDTH(W), .CHANNELS(CH), .RAMP_STEP(STEP), .DEAD_PERIODS(DEADP)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .speed_i       (speed),
    .mode_i        (mode),
    .pwm_cool_o    (pwm_cool),
    .pwm_heat_o    (pwm_heat),
    .duty_cur_o    (duty_cur),
    .period_start_o(period_start),
    .settled_o     (settled)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per channel, applied duty, active mode, mode seen at
  // the last period end and remaining dead periods (0 = not in dead time).
  int   m_cnt;
  int   m_duty[CH];
  int   m_act[CH];
  int   m_req[CH];
  int   m_dead[CH];
  logic e_ps;
  logic [CH-1:0] e_cool, e_heat, e_set;

  function automatic int toward(input int cur, input int tgt);
    int gap;
    gap = tgt - cur;
    if (gap > STEP)  gap = STEP;
    if (gap < -STEP) gap = -STEP;
    return cur + gap;
  endfunction

  function automatic int spd(input int c);
    return int'(speed[c*W +: W]);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    e_ps  = 1'b0;
    e_cool = '0;
    e_heat = '0;
    e_set  = '0;
    for (int c = 0; c < CH; c++) begin
      m_duty[c] = 0; m_act[c] = 0; m_req[c] = 0; m_dead[c] = 0;
    end
  endtask

  task automatic model_tick();
    logic on;
    e_ps = en && (m_cnt == 0);
    for (int c = 0; c < CH; c++) begin
      on = en && (m_dead[c] == 0) && (m_cnt < m_duty[c]);
      e_cool[c] = on && (m_act[c] == 0);
      e_heat[c] = on && (m_act[c] == 1);
      e_set[c]  = (m_dead[c] == 0) && (m_req[c] == m_act[c]) &&
                  (m_duty[c] == spd(c)) && (m_act[c] == int'(mode[c]));
    end
    if (en && m_cnt == PER - 1) begin
      for (int c = 0; c < CH; c++) begin
        m_req[c] = int'(mode[c]);
        if (m_dead[c] > 0) begin
          m_dead[c]--;
          if (m_dead[c] == 0) begin
            m_act[c]  = m_req[c];
            m_duty[c] = toward(m_duty[c], spd(c));
          end
        end else if (m_req[c] != m_act[c]) begin
          m_duty[c] = toward(m_duty[c], 0);
          if (m_duty[c] == 0) m_dead[c] = DEADP;
        end else begin
          m_duty[c] = toward(m_duty[c], spd(c));
        end
      end
    end
    m_cnt = en ? (m_cnt + 1) % PER : 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_tick();
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("period_start", int'(period_start), int'(e_ps));
      for (int c = 0; c < CH; c++) begin
        check($sformatf("cool[%0d]", c), int'(pwm_cool[c]), int'(e_cool[c]));
        check($sformatf("heat[%0d]", c), int'(pwm_heat[c]), int'(e_heat[c]));
        check($sformatf("interlock[%0d]", c), int'(pwm_cool[c] & pwm_heat[c]), 0);
        check($sformatf("settled[%0d]", c), int'(settled[c]), int'(e_set[c]));
        check($sformatf("duty[%0d]", c), int'(duty_cur[c*W +: W]), m_duty[c]);
      end
    end
  end

  // Measure one full period of channel 0 (aligned on period_start), with an
  // optional change of channel 0 speed/mode at clock chg_at of that period.
  task automatic per(input int chg_at, input int cs, input int cm,
                     input int ed, input int ec, input int eh, input string nm);
    int hc, hh, d0, k;
    k = 0;
    while (period_start !== 1'b1 && k < 700) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_sync"}, (k < 700) ? 1 : 0, 1);
    d0 = int'(duty_cur[W-1:0]);
    hc = 0;
    hh = 0;
    for (int i = 0; i < PER; i++) begin
      if (i == chg_at) begin
        if (cs >= 0) speed[W-1:0] = W'(cs);
        if (cm >= 0) mode[0] = cm[0];
      end
      hc += int'(pwm_cool[0]);
      hh += int'(pwm_heat[0]);
      @(negedge clk);
    end
    check({nm, "_duty"}, d0, ed);
    check({nm, "_cool_hi"}, hc, ec);
    check({nm, "_heat_hi"}, hh, eh);
  endtask

  initial begin
    int ch;
    int r;
    speed = {8'h20, 8'h40};
    mode  = 2'b10;
    repeat (3) @(negedge clk);
    check("rst_ps", int'(period_start), 0);
    check("rst_cool", int'(pwm_cool), 0);
    check("rst_heat", int'(pwm_heat), 0);
    check("rst_duty", int'(duty_cur), 0);
    check("rst_settled", int'(settled), 0);
    #2 rst = 1'b0;
    en = 1'b1;

    // Soft start 0 -> 0x40 in steps of 16, then down to 0x10
    per(-1, -1, -1, 0, 0, 0, "ramp0");
    per(-1, -1, -1, 16, 16, 0, "ramp16");
    per(-1, -1, -1, 32, 32, 0, "ramp32");
    per(-1, -1, -1, 48, 48, 0, "ramp48");
    per(-1, -1, -1, 64, 64, 0, "ramp64");
    check("settled_after_ramp", int'(settled[0]), 1);
    per(0, 'h10, -1, 64, 64, 0, "hold64");
    per(-1, -1, -1, 48, 48, 0, "down48");
    per(-1, -1, -1, 32, 32, 0, "down32");
    per(-1, -1, -1, 16, 16, 0, "down16");
    per(0, 'h40, -1, 16, 16, 0, "hold16");

    // Mid-period speed change does not affect the running period
    per(-1, -1, -1, 32, 32, 0, "up32");
    per(-1, -1, -1, 48, 48, 0, "up48");
    per(-1, -1, -1, 64, 64, 0, "up64");
    per(10, 'h80, -1, 64, 64, 0, "midchg");
    per(-1, -1, -1, 80, 80, 0, "up80");

    // en low: counter cleared, outputs low, duty held at 96
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("en0_cool", int'(pwm_cool[0]), 0);
      check("en0_ps", int'(period_start), 0);
      check("en0_duty", int'(duty_cur[W-1:0]), 96);
    end
    en = 1'b1;
    speed[W-1:0] = 8'h20;
    for (int d = 96; d >= 32; d -= 16) per(-1, -1, -1, d, d, 0, "down_to32");

    // cool -> heat: drain, two dead periods, heat ramp
    per(0, -1, 1, 32, 32, 0, "m2h_req");
    per(-1, -1, -1, 16, 16, 0, "m2h_drain");
    per(-1, -1, -1, 0, 0, 0, "m2h_dead1");
    per(-1, -1, -1, 0, 0, 0, "m2h_dead2");
    per(-1, -1, -1, 16, 0, 16, "m2h_heat16");
    per(-1, -1, -1, 32, 0, 32, "m2h_heat32");

    // Request reverted during drain: back up with no dead time
    per(0, -1, 0, 32, 0, 32, "rev_req");
    per(0, -1, 1, 16, 0, 16, "rev_drain");
    per(-1, -1, -1, 32, 0, 32, "rev_back32");
    per(0, 'h40, -1, 32, 0, 32, "rev_hold32");

    // Reset mid-ramp at duty 0x30
    repeat (20) @(negedge clk);
    check("pre_rst_duty", int'(duty_cur[W-1:0]), 48);
    #2 rst = 1'b1;
    #1;
    check("arst_cool", int'(pwm_cool), 0);
    check("arst_heat", int'(pwm_heat), 0);
    check("arst_duty", int'(duty_cur), 0);
    check("arst_ps", int'(period_start), 0);
    mode = 2'b00;
    @(negedge clk);
    #2 rst = 1'b0;
    per(-1, -1, -1, 0, 0, 0, "rs_ramp0");
    per(-1, -1, -1, 16, 16, 0, "rs_ramp16");
    per(-1, -1, -1, 32, 32, 0, "rs_ramp32");

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      r  = int'($urandom_range(0, 9999));
      ch = int'($urandom_range(0, CH - 1));
      if (r < 40) begin
        speed[ch*W +: W] = W'($urandom_range(0, 255));
      end else if (r < 45) begin
        mode[ch] = ~mode[ch];
      end else if (r < 47) begin
        en = 1'b0;
        repeat ($urandom_range(1, 30)) @(negedge clk);
        en = 1'b1;
      end else if (r == 47) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
